// File: rtl/l2_arb_ctrl.sv
// ---------------------------------------------------------------------------
// l2_arb_ctrl
//
// Arbitrates two cache back-ends (master 0 = icache, master 1 = dcache) onto
// a single L2 request port with one outstanding transaction, and sequences
// L2 invalidates so they never overlap an L2 request.
//
// Configuration macro:
//   L2_ARB_RR_EN  defined   -> round-robin between masters (pointer to the
//                              last-granted master, 1 after reset)
//                 undefined -> fixed priority, master 1 wins
//
// Ports:
//   clk_i, arst_n_i          clock (rising edge), async active-low reset
//   cke_i                    clock enable; low freezes all state
//   mN_valid_i/addr_i/
//   wdata_i/wstrb_i          master N request (wstrb 0 = read), held to ack
//   mN_ack_o, mN_rdata_o     master N completion, rdata valid with ack
//   s_valid_o/addr_o/
//   wdata_o/wstrb_o          L2 request, granted master's fields
//   s_ack_i, s_rdata_i       L2 completion pulse and read data
//   inv_req_i                invalidate request pulse from dcache
//   l2_inv_o                 single-cycle L2 invalidate
//   busy_o                   transaction/invalidate in progress or pending
// ---------------------------------------------------------------------------
module l2_arb_ctrl #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                m0_valid_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_ack_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_valid_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_ack_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_valid_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic                s_ack_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                inv_req_i,
  output logic                l2_inv_o,
  output logic                busy_o
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_INV  = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   grant_reg, grant_next;
  logic   pend_reg, pend_next;
  logic   pick;

  // Masters gathered into arrays so the granted one is a simple index.
  logic [1:0]        m_valid;
  logic [ADDR_W-1:0] m_addr  [2];
  logic [DATA_W-1:0] m_wdata [2];
  logic [STRB_W-1:0] m_wstrb [2];
  logic [1:0]        m_ack;
  logic [DATA_W-1:0] m_rdata [2];

  assign m_valid    = {m1_valid_i, m0_valid_i};
  assign m_addr[0]  = m0_addr_i;
  assign m_addr[1]  = m1_addr_i;
  assign m_wdata[0] = m0_wdata_i;
  assign m_wdata[1] = m1_wdata_i;
  assign m_wstrb[0] = m0_wstrb_i;
  assign m_wstrb[1] = m1_wstrb_i;

  // Completion routing: only the granted master ever sees ack or rdata.
  // The ack is qualified by cke_i so a frozen cycle never completes a
  // transaction that the state register has not retired.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      assign m_ack[gi]   = (state_reg == ST_BUSY) && cke_i && s_ack_i &&
                           (grant_reg == 1'(gi));
      assign m_rdata[gi] = m_ack[gi] ? s_rdata_i : '0;
    end
  endgenerate

  assign m0_ack_o   = m_ack[0];
  assign m1_ack_o   = m_ack[1];
  assign m0_rdata_o = m_rdata[0];
  assign m1_rdata_o = m_rdata[1];

  // Grant decision for the IDLE cycle. A single requester always wins, so
  // both schemes reduce to m_valid[1] unless both masters are requesting.
`ifdef L2_ARB_RR_EN
  logic last_reg, last_next;

  always_comb begin
    pick = m_valid[1];
    if (&m_valid) begin
      pick = ~last_reg;
    end
  end

  always_comb begin
    last_next = last_reg;
    if (cke_i && (state_reg == ST_IDLE) && !pend_reg && (|m_valid)) begin
      last_next = pick;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      last_reg <= 1'b1;
    end else begin
      last_reg <= last_next;
    end
  end
`else
  assign pick = m_valid[1];
`endif

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    pend_next  = pend_reg;
    if (cke_i) begin
      case (state_reg)
        ST_IDLE: begin
          // A pending invalidate is served before any new request.
          if (pend_reg) begin
            state_next = ST_INV;
          end else if (|m_valid) begin
            state_next = ST_BUSY;
            grant_next = pick;
          end
        end
        ST_BUSY: begin
          if (s_ack_i) begin
            state_next = ST_IDLE;
          end
        end
        ST_INV: begin
          state_next = ST_IDLE;
          pend_next  = 1'b0;
        end
        default: state_next = ST_IDLE;
      endcase
      // A new invalidate request beats the clear issued in INV.
      if (inv_req_i) begin
        pend_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_reg <= ST_IDLE;
      grant_reg <= 1'b0;
      pend_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      pend_reg  <= pend_next;
    end
  end

  assign s_valid_o = (state_reg == ST_BUSY) && m_valid[grant_reg];
  assign s_addr_o  = (state_reg == ST_BUSY) ? m_addr[grant_reg]  : '0;
  assign s_wdata_o = (state_reg == ST_BUSY) ? m_wdata[grant_reg] : '0;
  assign s_wstrb_o = (state_reg == ST_BUSY) ? m_wstrb[grant_reg] : '0;
  assign l2_inv_o  = (state_reg == ST_INV);
  assign busy_o    = (state_reg != ST_IDLE) || pend_reg;

endmodule

// File: tb/tb_l2_arb_ctrl.sv
module tb_l2_arb_ctrl;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          cke = 1'b1;
  logic [1:0]    mv = '0;
  logic [AW-1:0] ma [2];
  logic [DW-1:0] mw [2];
  logic [SW-1:0] ms [2];
  logic          s_ack = 1'b0;
  logic [DW-1:0] s_rdata = '0;
  logic          inv_req = 1'b0;

  logic          m0_ack, m1_ack, s_valid, l2_inv, busy;
  logic [DW-1:0] m0_rdata, m1_rdata, s_wdata;
  logic [AW-1:0] s_addr;
  logic [SW-1:0] s_wstrb;

  always #5 clk = ~clk;

  l2_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .m0_valid_i(mv[0]), .m0_addr_i(ma[0]), .m0_wdata_i(mw[0]), .m0_wstrb_i(ms[0]),
    .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_valid_i(mv[1]), .m1_addr_i(ma[1]), .m1_wdata_i(mw[1]), .m1_wstrb_i(ms[1]),
    .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .s_valid_o(s_valid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_ack_i(s_ack), .s_rdata_i(s_rdata),
    .inv_req_i(inv_req), .l2_inv_o(l2_inv), .busy_o(busy)
  );

  // Per-cycle expected status and expected completion/invalidate events.
  typedef struct {
    int            cyc;
    logic          sv;
    logic          busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
  } stat_t;

  typedef struct {
    int   cyc;
    logic [2:0] pat;   // {m1_ack, m0_ack, l2_inv}
  } ev_t;

  stat_t stat_q[$];
  ev_t   ev_q[$];
  int    dut_grants[$];
  bit    rec_grants = 1'b0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    cyc = 0;

  // Reference model: who owns the L2 port (-1 nobody, 0/1 a master,
  // 2 an invalidate), whether an invalidate is waiting, last winner.
  int owner = -1;
  bit inv_wait = 1'b0;
  int last_win = 1;
  bit mbusy [2];
  int swait = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Winner when the port is free and at least one master asks.
  function automatic int winner();
`ifdef L2_ARB_RR_EN
    if (mv == 2'b11) return (last_win == 0) ? 1 : 0;
`endif
    return mv[1] ? 1 : 0;
  endfunction

  // Predict this cycle's outputs from the current inputs, queue them,
  // advance the model, then move to the next cycle.
  task automatic step();
    stat_t s;
    ev_t   e;
    bit    np;
    s.cyc = cyc; s.sv = 0; s.busy = 0; s.addr = '0; s.wdata = '0; s.wstrb = '0;
    s.r0 = '0; s.r1 = '0;
    if (arst_n) begin
      if ((owner == 0 || owner == 1) && mv[owner]) begin
        s.sv = 1; s.addr = ma[owner]; s.wdata = mw[owner]; s.wstrb = ms[owner];
      end
      s.busy = (owner != -1) || inv_wait;
      if ((owner == 0 || owner == 1) && s_ack && cke) begin
        e.cyc = cyc; e.pat = (owner == 1) ? 3'b100 : 3'b010;
        ev_q.push_back(e);
        if (owner == 1) s.r1 = s_rdata; else s.r0 = s_rdata;
        mbusy[owner] = 1'b0;
      end
      if (owner == 2) begin
        e.cyc = cyc; e.pat = 3'b001;
        ev_q.push_back(e);
      end
    end
    stat_q.push_back(s);
    if (!arst_n) begin
      owner = -1; inv_wait = 1'b0; last_win = 1;
    end else if (cke) begin
      np = inv_wait;
      if (owner == -1) begin
        if (inv_wait) owner = 2;
        else if (mv != 2'b00) begin owner = winner(); last_win = owner; end
      end else if (owner == 2) begin
        owner = -1; np = 1'b0;
      end else if (s_ack) begin
        owner = -1;
      end
      if (inv_req) np = 1'b1;
      inv_wait = np;
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic masters_drive();
    for (int i = 0; i < 2; i++) begin
      if (!mbusy[i]) begin
        if ($urandom_range(0, 2) == 0) begin
          mbusy[i] = 1'b1; mv[i] = 1'b1;
          ma[i] = AW'($urandom); mw[i] = $urandom;
          ms[i] = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
        end else begin
          mv[i] = 1'b0;
        end
      end
    end
  endtask

  // L2 responder: acks a presented request after fixed_wait cycles
  // (random when negative); in random mode also throws stray acks.
  task automatic slave_drive(input int fixed_wait);
    bit sv;
    sv = arst_n && (owner == 0 || owner == 1) && mv[owner];
    s_ack = 1'b0;
    if (sv && cke) begin
      if (swait < 0) swait = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
      if (swait == 0) begin s_ack = 1'b1; s_rdata = $urandom; swait = -1; end
      else swait--;
    end else if (!sv && fixed_wait < 0 && cke && $urandom_range(0, 9) == 0) begin
      s_ack = 1'b1; s_rdata = $urandom;
    end
    if (!arst_n) swait = -1;
  endtask

  // Monitor: compare every presented cycle and every ack/invalidate.
  stat_t se;
  ev_t   ee;
  logic [2:0] outs;
  always @(negedge clk) begin
    while (stat_q.size() > 0 && stat_q[0].cyc < cyc) void'(stat_q.pop_front());
    if (stat_q.size() > 0 && stat_q[0].cyc == cyc) begin
      se = stat_q.pop_front();
      chk("s_valid", 64'(s_valid), 64'(se.sv));
      chk("busy", 64'(busy), 64'(se.busy));
      chk("s_addr", 64'(s_addr), 64'(se.addr));
      chk("s_wdata", 64'(s_wdata), 64'(se.wdata));
      chk("s_wstrb", 64'(s_wstrb), 64'(se.wstrb));
      chk("m0_rdata", 64'(m0_rdata), 64'(se.r0));
      chk("m1_rdata", 64'(m1_rdata), 64'(se.r1));
    end
    outs = {m1_ack, m0_ack, l2_inv};
    if (outs != 3'b000) begin
      if (rec_grants && (m0_ack || m1_ack)) dut_grants.push_back(m1_ack ? 1 : 0);
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        ee = ev_q.pop_front();
        chk("ack_inv_sel", 64'(outs), 64'(ee.pat));
      end else begin
        chk("spurious_out", 64'(outs), 64'(0));
      end
    end
    while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
      ee = ev_q.pop_front();
      chk("missing_out", 64'(outs), 64'(ee.pat));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g [4];
    for (int i = 0; i < 2; i++) begin ma[i] = '0; mw[i] = '0; ms[i] = '0; mbusy[i] = 1'b0; end
    #1;
    // Reset state
    repeat (3) step();
    arst_n = 1'b1;
    step();

    // Contention: both masters request continuously, L2 acks after 2 cycles
    ma[0] = 24'h000100; mw[0] = 32'h0; ms[0] = '0;
    ma[1] = 24'h000200; mw[1] = 32'h0; ms[1] = '0;
    mv = 2'b11; rec_grants = 1'b1;
    for (int k = 0; k < 60 && dut_grants.size() < 4; k++) begin
      slave_drive(2);
      step();
    end
    rec_grants = 1'b0; mv = 2'b00; s_ack = 1'b0; swait = -1;
    step();
`ifdef L2_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{1, 1, 1, 1};
`endif
    chk("grant_count", 64'(dut_grants.size()), 64'(4));
    for (int i = 0; i < 4 && i < dut_grants.size(); i++)
      chk("grant_order", 64'(dut_grants[i]), 64'(exp_g[i]));

    // Single read from master 0
    mv = 2'b01; ma[0] = 24'h000010; ms[0] = '0;
    step(); step();
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    step();
    s_ack = 1'b0; mv = 2'b00;
    step();

    // Invalidate while a master 1 write is outstanding
    mv = 2'b10; ma[1] = 24'h000033; mw[1] = 32'hCAFE0001; ms[1] = 4'hF;
    step(); step();
    inv_req = 1'b1; step();
    inv_req = 1'b0; step();
    s_ack = 1'b1; s_rdata = 32'h12345678; step();
    s_ack = 1'b0; mv = 2'b00;
    repeat (3) step();

    // Invalidate pending and master 0 request in the same IDLE cycle
    inv_req = 1'b1; step();
    inv_req = 1'b0; mv = 2'b01; ma[0] = 24'h000044; ms[0] = '0;
    repeat (3) step();
    s_ack = 1'b1; s_rdata = 32'h0BADF00D; step();
    s_ack = 1'b0; mv = 2'b00; step();

    // Reset in the middle of a transaction, then a master 1 only request
    mv = 2'b01; ma[0] = 24'h000055;
    step(); step();
    arst_n = 1'b0; mv = 2'b10; ma[1] = 24'h000066; mw[1] = 32'h66; ms[1] = 4'h3;
    step(); step();
    arst_n = 1'b1;
    step(); step();
    s_ack = 1'b1; s_rdata = 32'hA5A5A5A5; step();
    s_ack = 1'b0; mv = 2'b00; step();

    // Clock enable low for 3 cycles during BUSY
    mv = 2'b01; ma[0] = 24'h000077; ms[0] = '0;
    step(); step();
    cke = 1'b0; repeat (3) step();
    cke = 1'b1; step();
    s_ack = 1'b1; s_rdata = 32'h5A5A5A5A; step();
    s_ack = 1'b0; mv = 2'b00; step();

    // Randomized traffic with stray acks, invalidates, stalls and resets
    for (int k = 0; k < 2000; k++) begin
      if (!arst_n) arst_n = ($urandom_range(0, 1) == 0);
      else if ($urandom_range(0, 299) == 0) arst_n = 1'b0;
      cke = ($urandom_range(0, 9) != 0);
      masters_drive();
      slave_drive(-1);
      inv_req = cke && ($urandom_range(0, 19) == 0);
      step();
    end

    // Drain
    arst_n = 1'b1; cke = 1'b1; inv_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      slave_drive(0);
      if (!mbusy[0]) mv[0] = 1'b0;
      if (!mbusy[1]) mv[1] = 1'b0;
      step();
    end
    s_ack = 1'b0;
    step();
    chk("events_left", 64'(ev_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
